apb_mem_slave_p: RTL and testbench

- Parametrised APB4 completer with an internal register-file memory.
- Generalises the fixed 4-bit-address / 8-bit-data slave used under the current APB top.
- Adds configurable address/data width, depth, programmable wait states, byte strobes and PSLVERR on bad accesses.
- Sits behind the existing APB master in the APB top; one instance per peripheral slot.

---
 rtl/apb_mem_slave_p_if.sv | 37 +++
 rtl/apb_mem_slave_p.sv | 122 ++++++++++++
 tb/tb_apb_mem_slave_p.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_mem_slave_p_if.sv
// APB4 bus bundle between the existing APB master and one apb_mem_slave_p slot.
// Latency: none, wires only.
// Backpressure: the completer stretches transfers through pready.
// APB_SLV_PROT_EN adds the pprot field.
interface apb_mem_slave_p_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic            psel;
    logic            penable;
    logic            pwrite;
    logic [AW-1:0]   paddr;
    logic [DW-1:0]   pwdata;
    logic [DW/8-1:0] pstrb;
`ifdef APB_SLV_PROT_EN
    logic [2:0]      pprot;
`endif
    logic            pready;
    logic [DW-1:0]   prdata;
    logic            pslverr;

    modport master (
`ifdef APB_SLV_PROT_EN
        output pprot,
`endif
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
`ifdef APB_SLV_PROT_EN
        input  pprot,
`endif
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_mem_slave_p.sv
// APB4 completer backed by a DEPTH x DW register-file memory with byte strobes and PSLVERR.
// Latency: SETUP to pready=1 takes WAIT_CYCLES+1 cycles (2-cycle transfer when WAIT_CYCLES=0).
// Backpressure: holds pready=0 for WAIT_CYCLES ACCESS cycles; psel drop in ACCESS aborts.
// Optional macro APB_SLV_PROT_EN: adds pprot; unprivileged writes (pprot[0]=0) complete with an error.
module apb_mem_slave_p #(
    parameter int AW          = 8,
    parameter int DW          = 32,   // 8, 16, 32 or 64
    parameter int DEPTH       = 16,   // DEPTH*(DW/8) must fit in 2^AW bytes
    parameter int WAIT_CYCLES = 0     // 0..15
) (
    input  logic               clk,
    input  logic               rst,
    apb_mem_slave_p_if.slave   s
);
    localparam int NB    = DW / 8;
    localparam int ALIGN = $clog2(NB);
    localparam int IW    = AW - ALIGN;
    localparam int MIW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [IW:0] DEPTH_L = (IW+1)'(DEPTH);
    localparam logic [3:0]  WAIT_L  = 4'(WAIT_CYCLES);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    logic [0:0]     state_q;
    logic [3:0]     cnt_q;
    logic           err_q;
    logic           write_q;
    logic [MIW-1:0] idx_q;
    logic [DW-1:0]  rdata_q;
    logic [DW-1:0]  mem_q [DEPTH];

    logic           misalign;
    logic [IW-1:0]  idx_full;
    logic [MIW-1:0] idx_mem;
    logic           prot_err;
    logic           setup_err;
    logic           setup;
    logic           complete;

    // Word index and error decode, only meaningful in the SETUP cycle.
    assign idx_full = s.paddr[AW-1:ALIGN];
    assign idx_mem  = idx_full[MIW-1:0];

    generate
        if (ALIGN == 0) begin : g_noalign
            assign misalign = 1'b0;
        end else begin : g_align
            assign misalign = |s.paddr[ALIGN-1:0];
        end
    endgenerate

`ifdef APB_SLV_PROT_EN
    logic unused_prot_hi;
    assign unused_prot_hi = ^s.pprot[2:1];
    assign prot_err       = s.pwrite && !s.pprot[0];
`else
    assign prot_err       = 1'b0;
`endif

    assign setup_err = misalign || ({1'b0, idx_full} >= DEPTH_L) || prot_err;
    assign setup     = (state_q == ST_IDLE) && s.psel && !s.penable;
    // Completion requires psel still high; a dropped psel is an abort, not a completion.
    assign complete  = (state_q == ST_ACCESS) && s.psel && (cnt_q == 4'd0);

    // Response outputs are decoded from state and counter so pready lands exactly when the count expires.
    assign s.pready  = (state_q == ST_ACCESS) && (cnt_q == 4'd0);
    assign s.pslverr = s.pready && err_q;
    assign s.prdata  = (state_q == ST_ACCESS) ? rdata_q : '0;

    // Transfer FSM: capture the SETUP request, count wait states, return to IDLE on completion or abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            write_q <= 1'b0;
            idx_q   <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (setup) begin
                        state_q <= ST_ACCESS;
                        cnt_q   <= WAIT_L;
                        err_q   <= setup_err;
                        write_q <= s.pwrite;
                        idx_q   <= idx_mem;
                        rdata_q <= (!s.pwrite && !setup_err) ? mem_q[idx_mem] : '0;
                    end
                end
                default: begin
                    if (!s.psel) begin
                        state_q <= ST_IDLE;
                        rdata_q <= '0;
                    end else if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q <= ST_IDLE;
                        rdata_q <= '0;
                    end
                end
            endcase
        end
    end

    // Memory: cleared by reset, byte-lane write on an error-free completing write using live pwdata/pstrb.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (complete && write_q && !err_q) begin
            for (int b = 0; b < NB; b++) begin
                if (s.pstrb[b]) begin
                    mem_q[idx_q][b*8 +: 8] <= s.pwdata[b*8 +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_apb_mem_slave_p.sv
// Bench for apb_mem_slave_p: three instances (WAIT_CYCLES 0, 2, 3) driven by directed APB transfers.
// A transaction-level model predicts pready/pslverr/prdata each cycle; directed literals pin the model.
// Build with APB_SLV_PROT_EN defined to exercise the privilege check as well.
module tb_apb_mem_slave_p;
    localparam int ND = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [ND-1:0] psel;
    logic [ND-1:0] penable;
    logic [ND-1:0] pwrite;
    logic [7:0]    paddr  [ND];
    logic [31:0]   pwdata [ND];
    logic [3:0]    pstrb  [ND];
    logic [2:0]    pprot  [ND];
    logic [ND-1:0] pready_v;
    logic [ND-1:0] pslverr_v;
    logic [31:0]   prdata_a [ND];

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    function automatic int wait_of(int d);
        return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
    endfunction

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int W = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
        apb_mem_slave_p_if #(.AW(8), .DW(32)) bus ();
        assign bus.psel    = psel[g];
        assign bus.penable = penable[g];
        assign bus.pwrite  = pwrite[g];
        assign bus.paddr   = paddr[g];
        assign bus.pwdata  = pwdata[g];
        assign bus.pstrb   = pstrb[g];
`ifdef APB_SLV_PROT_EN
        assign bus.pprot   = pprot[g];
`endif
        assign pready_v[g]  = bus.pready;
        assign pslverr_v[g] = bus.pslverr;
        assign prdata_a[g]  = bus.prdata;
        apb_mem_slave_p #(.AW(8), .DW(32), .DEPTH(16), .WAIT_CYCLES(W)) u_dut (
            .clk (clk),
            .rst (rst),
            .s   (bus.slave)
        );
    end

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d got=%h want=%h at %0t", nm, d, act, exp, $time);
        end
    endtask

    // Transaction-level model: each transfer is "SETUP, then W wait cycles, then one completing cycle".
    logic [31:0] mmem [ND][16];
    bit          mact [ND];
    int          mage [ND];
    bit          merr [ND];
    bit          mwr  [ND];
    int          midx [ND];
    logic [31:0] mrd  [ND];

    always @(posedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (rst) begin
                for (int i = 0; i < 16; i++) mmem[d][i] = 32'h0;
                mact[d] = 1'b0;
                mage[d] = 0;
            end else if (!mact[d]) begin
                if (psel[d] && !penable[d]) begin
                    logic [7:0] a;
                    int idx;
                    bit e;
                    a   = paddr[d];
                    idx = int'(a) / 4;
                    e   = (a[1:0] != 2'b00) || (idx >= 16);
`ifdef APB_SLV_PROT_EN
                    if (pwrite[d] && !pprot[d][0]) e = 1'b1;
`endif
                    mact[d] = 1'b1;
                    mage[d] = 0;
                    merr[d] = e;
                    mwr[d]  = pwrite[d];
                    midx[d] = idx;
                    mrd[d]  = (!pwrite[d] && !e) ? mmem[d][idx] : 32'h0;
                end
            end else if (!psel[d]) begin
                mact[d] = 1'b0;
            end else if (mage[d] == wait_of(d)) begin
                if (mwr[d] && !merr[d]) begin
                    for (int b = 0; b < 4; b++)
                        if (pstrb[d][b]) mmem[d][midx[d]][b*8 +: 8] = pwdata[d][b*8 +: 8];
                end
                mact[d] = 1'b0;
            end else begin
                mage[d] = mage[d] + 1;
            end
        end
    end

    // Every-cycle comparison of all three instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < ND; d++) begin
                bit er;
                er = mact[d] && (mage[d] == wait_of(d));
                chk("cyc_pready", d, {31'h0, pready_v[d]}, {31'h0, er});
                chk("cyc_pslverr", d, {31'h0, pslverr_v[d]}, {31'h0, er && merr[d]});
                chk("cyc_prdata", d, prdata_a[d], mact[d] ? mrd[d] : 32'h0);
            end
        end
    end

    // One APB transfer; returns read data, error flag and number of pready=0 ACCESS cycles.
    task automatic xfer(input int d, input bit wr, input logic [7:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [2:0] prot,
                        output logic [31:0] rd, output logic er, output int nw);
        bit ok;
        ok = 1'b0;
        nw = 0;
        rd = 32'h0;
        er = 1'b0;
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
        paddr[d] = addr; pwdata[d] = data; pstrb[d] = strb; pprot[d] = prot;
        @(posedge clk); #1;
        penable[d] = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (pready_v[d]) begin
                rd = prdata_a[d];
                er = pslverr_v[d];
                ok = 1'b1;
            end else begin
                nw++;
                @(posedge clk); #1;
            end
        end
        if (ok) begin
            @(posedge clk); #1;
        end else begin
            chk("timeout", d, 32'h0, 32'h1);
        end
        psel[d] = 1'b0; penable[d] = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          nw;
    logic [31:0] sb [16];

    initial begin
        psel = '0; penable = '0; pwrite = '0;
        for (int d = 0; d < ND; d++) begin
            paddr[d] = 8'h0; pwdata[d] = 32'h0; pstrb[d] = 4'h0; pprot[d] = 3'b001;
        end
        @(posedge clk); #1;
        chk_en = 1'b1;
        for (int d = 0; d < ND; d++) begin
            chk("rst_pready", d, {31'h0, pready_v[d]}, 32'h0);
            chk("rst_prdata", d, prdata_a[d], 32'h0);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 1: read after reset
        xfer(0, 1'b0, 8'h00, 32'h0, 4'h0, 3'b001, rd, er, nw);
        chk("t1_rd", 0, rd, 32'h0);
        chk("t1_err", 0, {31'h0, er}, 32'h0);
        chk("t1_waits", 0, nw, 0);

        // 2: full write, readback, partial-strobe merge
        xfer(0, 1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 3'b001, rd, er, nw);
        chk("t2_werr", 0, {31'h0, er}, 32'h0);
        xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, 3'b001, rd, er, nw);
        chk("t2_rd", 0, rd, 32'hDEADBEEF);
        xfer(0, 1'b1, 8'h04, 32'h11223344, 4'b0101, 3'b001, rd, er, nw);
        xfer(0, 1'b0, 8'h04, 32'h0, 4'hF, 3'b001, rd, er, nw);
        chk("t2_merge", 0, rd, 32'hDE22BE44);

        // 3: wait states and back-to-back random traffic on the WAIT_CYCLES=3 instance
        for (int i = 0; i < 16; i++) sb[i] = 32'h0;
        xfer(2, 1'b1, 8'h08, 32'h0BADF00D, 4'hF, 3'b001, rd, er, nw);
        chk("t3_waits", 2, nw, 3);
        sb[2] = 32'h0BADF00D;
        for (int i = 0; i < 10; i++) begin
            int idx;
            logic [31:0] v;
            idx = int'($urandom_range(15, 0));
            v   = $urandom;
            xfer(2, 1'b1, 8'(idx * 4), v, 4'hF, 3'b001, rd, er, nw);
            sb[idx] = v;
        end
        for (int i = 0; i < 16; i++) begin
            xfer(2, 1'b0, 8'(i * 4), 32'h0, 4'h0, 3'b001, rd, er, nw);
            chk("t3_readback", 2, rd, sb[i]);
        end

        // 4: out-of-range write, misaligned and out-of-range reads
        xfer(0, 1'b1, 8'h40, 32'hFFFFFFFF, 4'hF, 3'b001, rd, er, nw);
        chk("t4_oor_werr", 0, {31'h0, er}, 32'h1);
        xfer(0, 1'b0, 8'h00, 32'h0, 4'h0, 3'b001, rd, er, nw);
        chk("t4_addr0", 0, rd, 32'h0);
        chk("t4_addr0_err", 0, {31'h0, er}, 32'h0);
        xfer(0, 1'b0, 8'h05, 32'h0, 4'h0, 3'b001, rd, er, nw);
        chk("t4_mis_err", 0, {31'h0, er}, 32'h1);
        chk("t4_mis_rd", 0, rd, 32'h0);
        xfer(0, 1'b0, 8'h44, 32'h0, 4'h0, 3'b001, rd, er, nw);
        chk("t4_oor_rerr", 0, {31'h0, er}, 32'h1);

        // 5a: abort by dropping psel in the first ACCESS cycle (WAIT_CYCLES=2)
        xfer(1, 1'b1, 8'h10, 32'h12345678, 4'hF, 3'b001, rd, er, nw);
        chk("t5_waits", 1, nw, 2);
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 8'h10; pwdata[1] = 32'hFFFFFFFF; pstrb[1] = 4'hF;
        @(posedge clk); #1;
        psel[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_abort_rdy", 1, {31'h0, pready_v[1]}, 32'h0);
        end
        @(posedge clk); #1;
        xfer(1, 1'b0, 8'h10, 32'h0, 4'h0, 3'b001, rd, er, nw);
        chk("t5_abort_mem", 1, rd, 32'h12345678);

        // 5b: reset in the middle of a write
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
        paddr[2] = 8'h0C; pwdata[2] = 32'hCAFEF00D; pstrb[2] = 4'hF;
        @(posedge clk); #1;
        penable[2] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        psel[2] = 1'b0; penable[2] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_rst_rdy", 2, {31'h0, pready_v[2]}, 32'h0);
        chk("t5_rst_rd", 2, prdata_a[2], 32'h0);
        @(posedge clk); #1;
        xfer(2, 1'b0, 8'h08, 32'h0, 4'h0, 3'b001, rd, er, nw);
        chk("t5_rst_mem08", 2, rd, 32'h0);
        xfer(2, 1'b0, 8'h0C, 32'h0, 4'h0, 3'b001, rd, er, nw);
        chk("t5_rst_mem0c", 2, rd, 32'h0);
        xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, 3'b001, rd, er, nw);
        chk("t5_rst_d0", 0, rd, 32'h0);

`ifdef APB_SLV_PROT_EN
        // 6: privilege check on writes; reads ignore pprot
        xfer(0, 1'b1, 8'h0C, 32'hA5A5A5A5, 4'hF, 3'b000, rd, er, nw);
        chk("t6_unpriv_err", 0, {31'h0, er}, 32'h1);
        xfer(0, 1'b0, 8'h0C, 32'h0, 4'h0, 3'b000, rd, er, nw);
        chk("t6_unpriv_rd", 0, rd, 32'h0);
        chk("t6_rd_err", 0, {31'h0, er}, 32'h0);
        xfer(0, 1'b1, 8'h0C, 32'hA5A5A5A5, 4'hF, 3'b001, rd, er, nw);
        chk("t6_priv_err", 0, {31'h0, er}, 32'h0);
        xfer(0, 1'b0, 8'h0C, 32'h0, 4'h0, 3'b000, rd, er, nw);
        chk("t6_priv_rd", 0, rd, 32'hA5A5A5A5);
`endif

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
